// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - operand fetch, MAC and result handshake bundle for matmul_sequencer
interface matmul_sequencer_if #(
  parameter int IDX_W = 2
);
  logic             start;
  logic             done;
  logic [IDX_W-1:0] a_i;
  logic [IDX_W-1:0] a_j;
  logic [IDX_W-1:0] b_i;
  logic [IDX_W-1:0] b_j;
  logic [31:0]      a_in;
  logic [31:0]      b_in;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic             mac_first;
  logic             mac_stb;
  logic             mac_ack;
  logic [31:0]      mac_result;
  logic [31:0]      z_out;
  logic [IDX_W-1:0] z_i;
  logic [IDX_W-1:0] z_j;
  logic             z_stb;
  logic             z_ack;

  modport master (
    input  start, a_in, b_in, mac_ack, mac_result, z_ack,
    output done, a_i, a_j, b_i, b_j, mac_a, mac_b, mac_first, mac_stb,
           z_out, z_i, z_j, z_stb
  );

  modport slave (
    output start, a_in, b_in, mac_ack, mac_result, z_ack,
    input  done, a_i, a_j, b_i, b_j, mac_a, mac_b, mac_first, mac_stb,
           z_out, z_i, z_j, z_stb
  );
endinterface

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - sequences Z = A x B through an external MAC, one result per handshake
// Optional run-length counter on port cycles when MATMUL_SEQ_CYCLE_COUNT_EN is defined.
module matmul_sequencer #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  output logic [31:0] cycles,
  matmul_sequencer_if.master bus
`else
  matmul_sequencer_if.master bus
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] i, j, k;
  logic [IDX_W-1:0] i_nx, j_nx, k_nx;
  logic [31:0]      z_q, z_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      z_q   <= '0;
    end else begin
      state <= state_nx;
      i     <= i_nx;
      j     <= j_nx;
      k     <= k_nx;
      z_q   <= z_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    i_nx          = i;
    j_nx          = j;
    k_nx          = k;
    z_nx          = z_q;
    bus.done      = 1'b0;
    bus.a_i       = '0;
    bus.a_j       = '0;
    bus.b_i       = '0;
    bus.b_j       = '0;
    bus.mac_a     = '0;
    bus.mac_b     = '0;
    bus.mac_first = 1'b0;
    bus.mac_stb   = 1'b0;
    bus.z_out     = z_q;
    bus.z_i       = '0;
    bus.z_j       = '0;
    bus.z_stb     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          i_nx     = '0;
          j_nx     = '0;
          k_nx     = '0;
          state_nx = ISSUE;
        end
      end

      // Operands follow the addresses combinationally, so holding k holds mac_a/mac_b.
      ISSUE: begin
        bus.a_i       = i;
        bus.a_j       = k;
        bus.b_i       = k;
        bus.b_j       = j;
        bus.mac_a     = bus.a_in;
        bus.mac_b     = bus.b_in;
        bus.mac_stb   = 1'b1;
        bus.mac_first = (k == '0);
        if (bus.mac_ack) begin
          if (k == LAST) begin
            z_nx     = bus.mac_result;
            k_nx     = '0;
            state_nx = WRITE;
          end else begin
            k_nx = k + ONE;
          end
        end
      end

      WRITE: begin
        bus.z_stb = 1'b1;
        bus.z_i   = i;
        bus.z_j   = j;
        if (bus.z_ack) begin
          if (j == LAST) begin
            j_nx = '0;
            if (i == LAST) begin
              state_nx = DONE;
            end else begin
              i_nx     = i + ONE;
              state_nx = ISSUE;
            end
          end else begin
            j_nx     = j + ONE;
            state_nx = ISSUE;
          end
        end
      end

      DONE: begin
        bus.done = 1'b1;
        if (!bus.start) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  // Counts ISSUE and WRITE cycles of the current run; frozen once DONE is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (state == IDLE) begin
      if (bus.start) cycles <= '0;
    end else if (state != DONE && cycles != '1) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer
`timescale 1ns/1ps
module tb_matmul_sequencer;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] amem [N][N];
  logic [31:0] bmem [N][N];
  logic [31:0] acc = 32'd0;
  int          zi_q [$];
  int          zj_q [$];
  logic [31:0] zv_q [$];
  bit          mod_a = 1'b0;
  int          n;

  matmul_sequencer_if #(.IDX_W(IDX_W)) bus ();

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycles;
  matmul_sequencer #(.N(N), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .cycles(cycles), .bus(bus));
`else
  matmul_sequencer #(.N(N), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  assign bus.a_in       = amem[bus.a_i][bus.a_j];
  assign bus.b_in       = bmem[bus.b_i][bus.b_j];
  assign bus.mac_result = (bus.mac_first ? 32'd0 : acc) + bus.mac_a * bus.mac_b;

  always @(posedge clk) if (bus.mac_stb && bus.mac_ack) acc <= bus.mac_result;

  always @(negedge clk) begin
    if (bus.z_stb && bus.z_ack) begin
      zi_q.push_back(int'(bus.z_i));
      zj_q.push_back(int'(bus.z_j));
      zv_q.push_back(bus.z_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit modified);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        amem[r][c] = (r == c) ? 32'd1 : 32'd0;
    if (modified) amem[0][1] = 32'd1;
    mod_a = modified;
  endtask

  // Identity A gives Z = B; the modified A adds row 1 of B into row 0.
  function automatic logic [31:0] z_exp(input int r, input int c);
    return (mod_a && r == 0) ? 32'(4 + 2 * c) : 32'(4 * r + c);
  endfunction

  task automatic clear_q();
    zi_q.delete();
    zj_q.delete();
    zv_q.delete();
  endtask

  task automatic run_count(output int cnt);
    tick();
    check("first_issue", 32'({bus.mac_stb, bus.mac_first, bus.a_i, bus.a_j, bus.b_i, bus.b_j}), 32'h300);
    cnt = 0;
    while (!bus.done && cnt < 400) begin
      tick();
      cnt++;
    end
    check("done_reached", 32'(bus.done), 32'd1);
  endtask

  task automatic check_results();
    check("z_count", 32'(zv_q.size()), 32'd16);
    for (int e = 0; e < zv_q.size() && e < 16; e++) begin
      check("z_row", 32'(zi_q[e]), 32'(e / 4));
      check("z_col", 32'(zj_q[e]), 32'(e % 4));
      check("z_val", zv_q[e], z_exp(e / 4, e % 4));
    end
  endtask

  task automatic end_run();
    bus.start = 1'b0;
    tick();
    check("idle_after_done", 32'(bus.done), 32'd0);
  endtask

  task automatic stall_mac();
    logic [31:0] ha, hb;
    logic        hf;
    int          w = 0;
    while (!(bus.mac_stb && bus.a_i == 2'd1 && bus.b_j == 2'd1 && bus.a_j == 2'd2) && w < 400) begin
      tick();
      w++;
    end
    check("mac_stall_seen", 32'(w < 400), 32'd1);
    ha = bus.mac_a;
    hb = bus.mac_b;
    hf = bus.mac_first;
    check("mac_b_11k2", hb, 32'd9);
    check("mac_first_k2", 32'(hf), 32'd0);
    bus.mac_ack = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("mac_a_hold", bus.mac_a, ha);
      check("mac_b_hold", bus.mac_b, hb);
      check("mac_first_hold", 32'(bus.mac_first), 32'(hf));
      check("k_hold", 32'(bus.a_j), 32'd2);
    end
    bus.mac_ack = 1'b1;
    tick();
    check("k_adv", 32'(bus.a_j), 32'd3);
  endtask

  task automatic stall_z();
    logic [31:0] hv;
    int          w = 0;
    while (!(bus.z_stb && bus.z_i == 2'd2 && bus.z_j == 2'd3) && w < 400) begin
      tick();
      w++;
    end
    check("z_stall_seen", 32'(w < 400), 32'd1);
    hv = bus.z_out;
    check("z_val_23", hv, 32'd11);
    bus.z_ack = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("z_stb_hold", 32'(bus.z_stb), 32'd1);
      check("z_out_hold", bus.z_out, hv);
      check("z_idx_hold", 32'({bus.z_i, bus.z_j}), 32'hB);
      check("mac_idle_wr", 32'(bus.mac_stb), 32'd0);
    end
    bus.z_ack = 1'b1;
    tick();
    check("z_stb_drop", 32'(bus.z_stb), 32'd0);
    check("next_issue", 32'({bus.mac_stb, bus.mac_first, bus.a_i, bus.b_j}), 32'h3C);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_stbs"}, 32'({bus.mac_stb, bus.mac_first, bus.z_stb}), 32'd0);
    check({tag, "_z_out"}, bus.z_out, 32'd0);
    check({tag, "_mac_a"}, bus.mac_a, 32'd0);
    check({tag, "_mac_b"}, bus.mac_b, 32'd0);
    check({tag, "_idx"}, 32'({bus.a_i, bus.a_j, bus.b_i, bus.b_j, bus.z_i, bus.z_j}), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        bmem[r][c] = 32'(4 * r + c);
    set_a(1'b0);
    bus.start   = 1'b0;
    bus.mac_ack = 1'b1;
    bus.z_ack   = 1'b1;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_zero_outputs("reset");
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    check("cycles_reset", cycles, 32'd0);
`endif

    // Identity A, acks tied high, start left high through the run.
    clear_q();
    bus.start = 1'b1;
    run_count(n);
    check("run_len", 32'(n), 32'd80);
    check_results();
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    check("cycles_done", cycles, 32'd80);
`endif
    for (int s = 0; s < 3; s++) begin
      tick();
      check("done_hold", 32'(bus.done), 32'd1);
      check("no_rerun", 32'(bus.mac_stb), 32'd0);
    end
    check("no_extra_z", 32'(zv_q.size()), 32'd16);
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    check("cycles_hold", cycles, 32'd80);
`endif
    end_run();
    check("z_out_kept", bus.z_out, 32'd15);

    // MAC accept withheld at k=2 of element (1,1).
    set_a(1'b1);
    clear_q();
    bus.start = 1'b1;
    fork
      run_count(n);
      stall_mac();
    join
    check("run_len_mac_stall", 32'(n), 32'd83);
    check_results();
    end_run();

    // Result accept delayed at element (2,3).
    clear_q();
    bus.start = 1'b1;
    fork
      run_count(n);
      stall_z();
    join
    check("run_len_z_stall", 32'(n), 32'd85);
    check_results();
    end_run();

    // Reset during WRITE of element (0,2), then restart with start still high.
    clear_q();
    bus.start = 1'b1;
    n = 0;
    while (!(bus.z_stb && bus.z_i == 2'd0 && bus.z_j == 2'd2) && n < 400) begin
      tick();
      n++;
    end
    check("write02_seen", 32'(n < 400), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("mid_reset");
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    check("cycles_mid_reset", cycles, 32'd0);
`endif
    clear_q();
    run_count(n);
    check("run_len_restart", 32'(n), 32'd80);
    check_results();
    end_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
